// File: rtl/pipo_rr_arbiter_if.sv
// pipo_rr_arbiter_if: requester-side bus of the round-robin PIPO write arbiter.
//
// Optional feature macro: PIPO_ARB_LOCK_EN (adds the per-requester lock vector).
//
// Signals:
//   req      per-requester write request, level-sensitive
//   din      packed words, requester i drives din[i*WIDTH +: WIDTH]
//   lock     per-requester burst hold (only with PIPO_ARB_LOCK_EN)
//   ack      one-hot write acknowledge, registered
//   q        PIPO register contents, registered
//   q_valid  high once q has been written since reset
//   owner    index of the requester that last wrote q
//
// Modports: master = requester/producer side, slave = arbiter side.
interface pipo_rr_arbiter_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NREQ  = 4
);
    localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] din;
`ifdef PIPO_ARB_LOCK_EN
    logic [NREQ-1:0]       lock;
`endif
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      q;
    logic                  q_valid;
    logic [OW-1:0]         owner;

`ifdef PIPO_ARB_LOCK_EN
    modport master (output req, din, lock, input ack, q, q_valid, owner);
    modport slave  (input req, din, lock, output ack, q, q_valid, owner);
`else
    modport master (output req, din, input ack, q, q_valid, owner);
    modport slave  (input req, din, output ack, q, q_valid, owner);
`endif
endinterface

// File: rtl/pipo_rr_arbiter.sv
// pipo_rr_arbiter: round-robin write arbiter sharing one internal PIPO register
// among NREQ requesters. A grant loads the winner's word into q, records the
// winner in owner and pulses its ack for one cycle; the cycle after a grant is
// a blanking (ACK) cycle in which no grant is made.
//
// Optional feature macro: PIPO_ARB_LOCK_EN. When defined, a requester holding
// both req and lock through its ACK cycle enters HOLD and streams one word per
// cycle until it drops either signal.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-low reset, dominates all inputs
//   bus    pipo_rr_arbiter_if.slave (req/din/[lock] in, ack/q/q_valid/owner out)
module pipo_rr_arbiter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned NREQ  = 4
) (
    input  logic             clk,
    input  logic             reset,
    pipo_rr_arbiter_if.slave bus
);
    localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef PIPO_ARB_LOCK_EN
    typedef enum logic [1:0] {StArb, StAck, StHold} state_e;
`else
    typedef enum logic [1:0] {StArb, StAck} state_e;
`endif

    state_e           state_q;
    logic [OW-1:0]    ptr_q;
    logic [WIDTH-1:0] data_q;
    logic [OW-1:0]    owner_q;
    logic [NREQ-1:0]  ack_q;
    logic             valid_q;

    logic [OW-1:0]    winner;
    logic [OW-1:0]    ptr_next;
    logic [NREQ-1:0]  winner_onehot;
    logic [WIDTH-1:0] winner_data;

    // Scan ptr, ptr+1, ..., wrapping modulo NREQ; first set request wins.
    always_comb begin
        int unsigned idx;
        logic [OW-1:0] cand;
        logic found;
        winner = ptr_q;
        found  = 1'b0;
        idx    = 0;
        cand   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = OW'(idx);
            if (!found && bus.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        winner_onehot         = '0;
        winner_onehot[winner] = 1'b1;
        winner_data           = bus.din[winner*WIDTH +: WIDTH];
        ptr_next              = (winner == OW'(NREQ - 1)) ? '0 : winner + OW'(1);
    end

`ifdef PIPO_ARB_LOCK_EN
    logic             hold_ok;
    logic [NREQ-1:0]  owner_onehot;
    logic [WIDTH-1:0] owner_data;

    always_comb begin
        hold_ok                = bus.req[owner_q] && bus.lock[owner_q];
        owner_onehot           = '0;
        owner_onehot[owner_q]  = 1'b1;
        owner_data             = bus.din[owner_q*WIDTH +: WIDTH];
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StArb;
            ptr_q   <= '0;
            data_q  <= '0;
            owner_q <= '0;
            ack_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StArb: begin
                    if (|bus.req) begin
                        data_q  <= winner_data;
                        owner_q <= winner;
                        valid_q <= 1'b1;
                        ack_q   <= winner_onehot;
                        ptr_q   <= ptr_next;
                        state_q <= StAck;
                    end else begin
                        ack_q <= '0;
                    end
                end
                // Blanking cycle: the winner may still hold req while it sees ack.
                StAck: begin
                    ack_q <= '0;
`ifdef PIPO_ARB_LOCK_EN
                    state_q <= hold_ok ? StHold : StArb;
`else
                    state_q <= StArb;
`endif
                end
`ifdef PIPO_ARB_LOCK_EN
                // Streaming burst; ptr already points past the owner.
                StHold: begin
                    if (hold_ok) begin
                        data_q <= owner_data;
                        ack_q  <= owner_onehot;
                    end else begin
                        ack_q   <= '0;
                        state_q <= StArb;
                    end
                end
`endif
                default: begin
                    ack_q   <= '0;
                    state_q <= StArb;
                end
            endcase
        end
    end

    assign bus.ack     = ack_q;
    assign bus.q       = data_q;
    assign bus.q_valid = valid_q;
    assign bus.owner   = owner_q;
endmodule

// File: tb/tb_pipo_rr_arbiter.sv
// Directed self-checking bench for pipo_rr_arbiter (WIDTH=4, NREQ=4).
// The lock scenario is only exercised when PIPO_ARB_LOCK_EN is defined.
module tb_pipo_rr_arbiter;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned NREQ  = 4;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pipo_rr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    pipo_rr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] ack, input logic [3:0] q,
                             input logic qv, input logic [1:0] owner);
        check({tag, ".ack"}, 32'(bus.ack), 32'(ack));
        check({tag, ".q"}, 32'(bus.q), 32'(q));
        check({tag, ".q_valid"}, 32'(bus.q_valid), 32'(qv));
        check({tag, ".owner"}, 32'(bus.owner), 32'(owner));
    endtask

    initial begin
        logic [1:0] exp_owner;
        checks = 0;
        errors = 0;

        // 1. Reset dominates active requests.
        reset   = 1'b0;
        bus.req = 4'b1111;
        bus.din = 16'hBBBB;
`ifdef PIPO_ARB_LOCK_EN
        bus.lock = 4'b0000;
`endif
        step();
        check_all("reset0", 4'b0000, 4'h0, 1'b0, 2'd0);
        step();
        check_all("reset1", 4'b0000, 4'h0, 1'b0, 2'd0);

        // Idle ARB: nothing happens.
        reset   = 1'b1;
        bus.req = 4'b0000;
        step();
        check_all("idle", 4'b0000, 4'h0, 1'b0, 2'd0);

        // 2. Single request from requester 2.
        bus.req = 4'b0100;
        bus.din = 16'h0B00;
        step();
        check_all("single_grant", 4'b0100, 4'hB, 1'b1, 2'd2);
        bus.req = 4'b0000;
        step();
        check_all("single_ack", 4'b0000, 4'hB, 1'b1, 2'd2);

        // 3. Full contention from a fresh reset (ptr=0).
        reset = 1'b0;
        step();
        reset   = 1'b1;
        bus.req = 4'b1111;
        bus.din = 16'h4321;
        for (int k = 0; k < 10; k++) begin
            step();
            check("contend.onehot", 32'($countones(bus.ack) <= 1), 32'd1);
            if (k % 2 == 0) begin
                exp_owner = 2'((k / 2) % 4);
                check("contend.owner", 32'(bus.owner), 32'(exp_owner));
                check("contend.q", 32'(bus.q), 32'(exp_owner) + 32'd1);
                check("contend.ack", 32'(bus.ack), 32'd1 << exp_owner);
            end else begin
                check("contend.blank", 32'(bus.ack), 32'd0);
            end
        end

        // 4. Wrap-around: grant to 3 leaves ptr=0, then 1001 -> 0 then 3.
        bus.req = 4'b1000;
        step();
        check_all("wrap_g3", 4'b1000, 4'h4, 1'b1, 2'd3);
        bus.req = 4'b1001;
        step();
        check("wrap_blank0", 32'(bus.ack), 32'd0);
        step();
        check_all("wrap_g0", 4'b0001, 4'h1, 1'b1, 2'd0);
        step();
        check("wrap_blank1", 32'(bus.ack), 32'd0);
        step();
        check_all("wrap_g3b", 4'b1000, 4'h4, 1'b1, 2'd3);
        bus.req = 4'b0000;
        step();
        check("wrap_blank2", 32'(bus.ack), 32'd0);

        // 5. Reset in the ACK cycle after a grant to requester 2.
        bus.req = 4'b0100;
        step();
        check_all("mid_g2", 4'b0100, 4'h3, 1'b1, 2'd2);
        reset = 1'b0;
        step();
        check_all("mid_reset", 4'b0000, 4'h0, 1'b0, 2'd0);
        reset   = 1'b1;
        bus.req = 4'b1111;
        step();
        check_all("mid_first", 4'b0001, 4'h1, 1'b1, 2'd0);
        bus.req = 4'b0000;
        step();
        check("mid_blank", 32'(bus.ack), 32'd0);

`ifdef PIPO_ARB_LOCK_EN
        // 6. Locked burst from requester 1 (ptr=1 here).
        bus.req  = 4'b0010;
        bus.lock = 4'b0010;
        bus.din  = 16'h0010;
        step();
        check_all("lock_grant", 4'b0010, 4'h1, 1'b1, 2'd1);
        bus.din = 16'h0020;
        step();
        check_all("lock_ackcyc", 4'b0000, 4'h1, 1'b1, 2'd1);
        bus.din = 16'h0030;
        step();
        check_all("lock_stream0", 4'b0010, 4'h3, 1'b1, 2'd1);
        bus.din = 16'h0040;
        step();
        check_all("lock_stream1", 4'b0010, 4'h4, 1'b1, 2'd1);
        bus.lock = 4'b0000;
        bus.req  = 4'b0011;
        bus.din  = 16'h0057;
        step();
        check_all("lock_exit", 4'b0000, 4'h4, 1'b1, 2'd1);
        step();
        check_all("lock_next", 4'b0001, 4'h7, 1'b1, 2'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pipo_rr_arbiter.md
# pipo_rr_arbiter

Round-robin write arbiter that shares one PIPO buffer register between several requesters. Each requester presents a parallel word with a request. The arbiter grants one requester at a time and loads the winner's word into the register in parallel. It returns a one-cycle acknowledge to the winner and exposes the register contents together with the owning requester's index. It sits between the producer blocks and the PIPO register stage, and contains that register internally.

## Interface
- WIDTH, 4, data word width in bits (1..32).
- NREQ, 4, number of requesters (2..8).
- clk  in  1  single clock; everything is updated on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- req  in  NREQ  per-requester write request, level-sensitive.
- din  in  NREQ*WIDTH  packed words; requester i drives din[i*WIDTH +: WIDTH].
- lock  in  NREQ  per-requester burst hold; present only with PIPO_ARB_LOCK_EN.
- ack  out  NREQ  one-hot write acknowledge, registered.
- q  out  WIDTH  PIPO register contents, registered.
- q_valid  out  1  high once q has been written since reset.
- owner  out  max(1,$clog2(NREQ))  index of the requester that last wrote q.

## Operation
- Internal state: FSM {ARB, ACK, HOLD}, plus round-robin pointer ptr of owner width.
- Reset (reset==0 at an edge) sets:
  - q=0, q_valid=0, ack=0, owner=0;
  - ptr=0, state=ARB;
  - reset dominates all other inputs.
- ARB with req==0: no change and ack=0.
- ARB with any req bit set:
  - winner = first set bit scanning ptr, ptr+1, …, NREQ-1, 0, …, ptr-1 (modular wrap);
  - at the edge: q<=din[winner], owner<=winner, q_valid<=1, ack<=one-hot(winner);
  - ptr<=(winner+1) mod NREQ, state<=ACK.
- ACK: no grant is made in this state.
  - At the edge, ack<=0 and state<=ARB.
  - This blanks the cycle in which the winner still holds req while it sees ack.
- A requester that holds req past its ack cycle is treated as a new request. It is then lowest priority, because ptr has already moved past it.
- Dropping req during the ACK cycle has no effect: the write is already committed.
- q and owner hold their value until the next grant. q_valid never falls except on reset.
- HOLD is unreachable without PIPO_ARB_LOCK_EN.

## Timing
- A request sampled at edge k (state ARB) gives q, owner and ack valid after edge k.
- Latency is 1 cycle from request to q and ack.
- ack is high for exactly 1 cycle per grant (non-lock mode).
- Peak throughput is one write per 2 cycles. The earliest next grant is at edge k+2.
- Simultaneous requests are resolved in a single cycle with no extra latency.
- Reset asserted during ACK or HOLD: outputs are cleared after that edge, and the first grant after reset starts from requester 0.

## Configuration
- PIPO_ARB_LOCK_EN defined:
  - the lock port exists;
  - in ACK, if req[owner] && lock[owner], state<=HOLD instead of ARB.
- Behaviour in HOLD:
  - each edge with req[owner] && lock[owner]: q<=din[owner] and ack[owner]<=1 (streaming, one word per cycle);
  - otherwise: ack<=0 and state<=ARB;
  - ptr is unchanged, so arbitration resumes after the locked requester.
- PIPO_ARB_LOCK_EN undefined:
  - there is no lock port and no HOLD state;
  - behaviour is pure alternating ARB/ACK.

## Test plan
All scenarios use WIDTH=4 and NREQ=4.
1. Reset: reset=0 for 2 cycles with req=1111 and din all 1011 -> q=0000, q_valid=0, ack=0000, owner=0 throughout.
2. Single request: req=0100, din[2]=1011 -> after the next edge ack=0100, q=1011, owner=2, q_valid=1; one edge later ack=0000 and q holds 1011.
3. Full contention: req=1111 held, din[i]=i+1 -> grants to owners 0,1,2,3,0 on every second edge; q steps 0001,0010,0011,0100,0001; ack is never two-hot.
4. Wrap-around: after a grant to owner 3 (ptr=0), req=1001 -> owner 0 first, then owner 3 two cycles later.
5. Reset mid-operation: reset=0 in the ACK cycle after a grant to owner 2 -> next edge q=0000, q_valid=0, ack=0000; then req=1111 -> owner 0 wins first.
6. Lock (macro defined): req=0010, lock=0010, din[1] stepping 0001,0010,0011 each cycle.
   - Expected: q follows din[1] with 1-cycle latency after the ACK cycle, and ack=0010 stays high.
   - Then lock drops with req=0011 -> state returns to ARB and the next grant goes to requester 0 (ptr=2 wraps through 3 to 0).
